// File: rtl/linear_requant_pkg.sv
// Shared definitions for the linear requantisation stage: default widths,
// int8 limits, the output saturation helper and the neuron index width helper.
package linear_pkg;

    localparam int ACC_WIDTH_DEFAULT  = 32;
    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int INT8_MAX           = 127;
    localparam int INT8_MIN           = -128;

    // Width of the working value handed to saturate(); the widest
    // intermediate in the datapath must fit inside it.
    localparam int SAT_WIDTH = 64;

    // Number of bits needed to index n entries, never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a signed value to the range of a signed integer of the given width.
    function automatic logic signed [SAT_WIDTH-1:0] saturate(
        input logic signed [SAT_WIDTH-1:0] value,
        input int                          width
    );
        logic signed [SAT_WIDTH-1:0] max_v;
        logic signed [SAT_WIDTH-1:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/linear_requant_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on
// rd_data whenever the FIFO is not empty; a push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module sync_fifo
    import linear_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = idx_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Empty FIFO presents zeros so the consumer never sees stale payload.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/linear_requant.sv
// Requantisation stage after the int8 linear layer: bias add, fixed-point
// scale with round-half-up shift, optional ReLU, int8 saturation, and an
// output FIFO with a valid/ready handshake.
module linear_requant
    import linear_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_WIDTH_DEFAULT,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int NUM_NEURONS = 64,
    parameter int MULT_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  valid_in,
    input  logic signed [ACC_WIDTH-1:0]           acc_in,
    input  logic                                  bias_wr_en,
    input  logic [idx_width(NUM_NEURONS)-1:0]     bias_wr_addr,
    input  logic signed [ACC_WIDTH-1:0]           bias_wr_data,
    input  logic [MULT_WIDTH-1:0]                 scale_mult,
    input  logic [SHIFT_WIDTH-1:0]                scale_shift,
    input  logic                                  relu_en,
    input  logic                                  overflow_clr,
    output logic signed [DATA_WIDTH-1:0]          out_data,
    output logic [idx_width(NUM_NEURONS)-1:0]     out_idx,
    output logic                                  out_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  overflow
);

    localparam int IDX_W  = idx_width(NUM_NEURONS);
    localparam int SUM_W  = ACC_WIDTH + 1;
    localparam int PROD_W = ACC_WIDTH + MULT_WIDTH + 2;
    localparam int RND_W  = PROD_W + 1;
    localparam int PAY_W  = IDX_W + 1 + DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic signed [ACC_WIDTH-1:0]  bias_mem [NUM_NEURONS];
    logic signed [ACC_WIDTH-1:0]  bias_rd;
    logic [IDX_W-1:0]             cnt;

    logic                         s1_valid;
    logic signed [SUM_W-1:0]      s1_sum;
    logic [IDX_W-1:0]             s1_idx;
    logic                         s2_valid;
    logic signed [PROD_W-1:0]     s2_prod;
    logic [IDX_W-1:0]             s2_idx;
    logic                         s3_valid;
    logic signed [DATA_WIDTH-1:0] s3_data;
    logic [IDX_W-1:0]             s3_idx;
    logic                         s3_last;

    logic signed [SUM_W-1:0]      sum_next;
    logic signed [PROD_W-1:0]     sum_ext;
    logic signed [PROD_W-1:0]     mult_ext;
    logic signed [PROD_W-1:0]     prod_next;
    logic signed [RND_W-1:0]      prod_wide;
    logic signed [RND_W-1:0]      rnd_add;
    logic signed [RND_W-1:0]      rounded;
    logic signed [RND_W-1:0]      relu_val;
    logic signed [DATA_WIDTH-1:0] data_next;

    logic [PAY_W-1:0]             head;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         pop;

    // Bias table write port; a read of the same entry in this cycle still sees the old value.
    always_ff @(posedge clk) begin
        if (bias_wr_en && ({1'b0, bias_wr_addr} < (IDX_W + 1)'(NUM_NEURONS))) begin
            bias_mem[bias_wr_addr] <= bias_wr_data;
        end
    end

    // Datapath arithmetic for all three stages, widened so no stage can overflow.
    always_comb begin
        bias_rd   = bias_mem[cnt];
        sum_next  = {acc_in[ACC_WIDTH-1], acc_in} + {bias_rd[ACC_WIDTH-1], bias_rd};

        sum_ext   = {{(PROD_W - SUM_W){s1_sum[SUM_W-1]}}, s1_sum};
        mult_ext  = {{(PROD_W - MULT_WIDTH){1'b0}}, scale_mult};
        prod_next = sum_ext * mult_ext;

        prod_wide = {s2_prod[PROD_W-1], s2_prod};
        rnd_add   = '0;
        if (scale_shift != '0) begin
            rnd_add = RND_W'(1) << (scale_shift - 1'b1);
        end
        rounded   = (prod_wide + rnd_add) >>> scale_shift;

        relu_val  = rounded;
        if (relu_en && rounded[RND_W-1]) begin
            relu_val = '0;
        end
        data_next = DATA_WIDTH'(saturate(SAT_WIDTH'(relu_val), DATA_WIDTH));
    end

    // Stage 1: bias add and neuron tagging; the counter only moves on accepted inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_sum <= sum_next;
                s1_idx <= cnt;
                cnt    <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
            end
        end
    end

    // Stage 2: scale multiply with the unsigned multiplier treated as positive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_idx   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod <= prod_next;
                s2_idx  <= s1_idx;
            end
        end
    end

    // Stage 3: rounding shift, ReLU and saturation into the FIFO payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_data  <= '0;
            s3_idx   <= '0;
            s3_last  <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_data <= data_next;
                s3_idx  <= s2_idx;
                s3_last <= (s2_idx == LAST_IDX);
            end
        end
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign {out_idx, out_last, out_data} = head;

    // Sticky drop flag; a new drop in the same cycle wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (s3_valid && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s3_valid),
        .push_data ({s3_idx, s3_last, s3_data}),
        .pop       (pop),
        .rd_data   (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
